id_forward_stage: RTL and testbench
===================================

ID_FORWARD_STAGE -- requirements
Module: id_forward_stage

Interface
REQ-001 DATA_WIDTH, 32, width of register values.
REQ-002 REG_COUNT, 32, architectural register count; AW = clog2(REG_COUNT); register 0 reads as zero.
REQ-003 CTRL_WIDTH, 16, width of opaque decoded control bundle carried to EX.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 id_valid  in  1  instruction in ID is real (not a bubble).
REQ-007 id_rs  in  AW  source register A address.
REQ-008 id_rt  in  AW  source register B address.
REQ-009 id_usesRs  in  1  instruction reads rs.
REQ-010 id_usesRt  in  1  instruction reads rt.
REQ-011 id_isBranch  in  1  instruction consumes rsValue/rtValue in ID (branch compare, jr).
REQ-012 id_isLoad  in  1  instruction is a memory load.
REQ-013 id_writeRegister  in  1  instruction writes a register.
REQ-014 id_writeAddress  in  AW  destination register address.
REQ-015 id_ctrl  in  CTRL_WIDTH  decoded control bundle.
REQ-016 flush  in  1  squash the instruction in ID (taken branch/jump).
REQ-017 ex_result  in  DATA_WIDTH  combinational EX result of the instruction held in the ID/EX register.
REQ-018 mem_writeRegister  in  1  MEM-stage instruction writes a register.
REQ-019 mem_writeAddress  in  AW  MEM-stage destination.
REQ-020 mem_data  in  DATA_WIDTH  MEM-stage final value (ALU or load data).
REQ-021 wb_writeRegister  in  1  register file write enable.
REQ-022 wb_writeAddress  in  AW  register file write address.
REQ-023 wb_writeData  in  DATA_WIDTH  register file write data.
REQ-024 shouldStall  out  1  hold PC and IF/ID this cycle.
REQ-025 rsValue  out  DATA_WIDTH  forwarded rs value, combinational.
REQ-026 rtValue  out  DATA_WIDTH  forwarded rt value, combinational.
REQ-027 ex_valid  out  1  ID/EX register holds a real instruction.
REQ-028 ex_rsValue  out  DATA_WIDTH  registered rsValue.
REQ-029 ex_rtValue  out  DATA_WIDTH  registered rtValue.
REQ-030 ex_ctrl  out  CTRL_WIDTH  registered control bundle.
REQ-031 ex_writeRegister  out  1  registered write enable.
REQ-032 ex_writeAddress  out  AW  registered destination.
REQ-033 ex_isLoad  out  1  registered load flag.

Function
REQ-034 Register file: REG_COUNT x DATA_WIDTH, written at rising edge when wb_writeRegister and wb_writeAddress != 0; entry 0 never written.
REQ-035 Operand select per source (rs, rt independently), first match wins: address 0 -> 0; EX hit (ex_valid, ex_writeRegister, !ex_isLoad, ex_writeAddress == addr) -> ex_result; MEM hit -> mem_data; WB hit -> wb_writeData (same-cycle write-through); else file contents.
REQ-036 Load-use hazard: ex_valid & ex_isLoad & ex_writeRegister & ex_writeAddress != 0 & id_valid & ((id_usesRs & id_rs == ex_writeAddress) | (id_usesRt & id_rt == ex_writeAddress)).
REQ-037 Branch hazard: id_valid & id_isBranch & MEM-stage load result not yet... excluded -- mem_data is final, so only REQ-036 applies to branches; a branch on an EX ALU result forwards ex_result with no stall.
REQ-038 shouldStall = load-use hazard, combinational, independent of flush; stall length exactly 1 cycle per hazard.
REQ-039 ID/EX update each rising edge: if flush, stall or !id_valid -> bubble (ex_valid=0, ex_writeRegister=0, ex_isLoad=0, ex_ctrl=0, data don't-care); else capture id_* fields, rsValue, rtValue, ex_valid=1.
REQ-040 Flush and stall in same cycle -> bubble; flush has priority; shouldStall still reflects REQ-036.

Reset
REQ-041 While reset low: all register file entries 0, ex_valid=0, ex_writeRegister=0, ex_isLoad=0, ex_ctrl=0, ex_rsValue=ex_rtValue=0, ex_writeAddress=0; reset mid-stall drops the pending instruction.

Verification
REQ-042 WB writes r5=0x1234 while ID reads rs=5 same cycle -> rsValue=0x1234; next cycle file read also 0x1234.
REQ-043 EX holds ALU to r3 with ex_result=7, MEM writes r3=9, ID reads rt=3 -> rtValue=7 (EX priority); remove EX hit -> 9.
REQ-044 EX holds load to r4, ID add uses r4 -> shouldStall=1 one cycle, ex_valid=0 next edge; following cycle forwarding from MEM, no stall.
REQ-045 ID reads r0 while EX/MEM/WB all target r0 with 0xFFFF -> rsValue=0, no stall.
REQ-046 flush=1 with valid ID instruction -> ex_valid=0, ex_writeRegister=0 next edge; reset asserted mid-operation -> all outputs per REQ-041 immediately.

Source files
------------

// File: rtl/id_forward_stage.sv
// rtl/id_forward_stage.sv - ID stage register file, operand forwarding, load-use interlock and ID/EX register
module id_forward_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int CTRL_WIDTH = 16,
  parameter int AW         = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [AW-1:0]         id_rs,
  input  logic [AW-1:0]         id_rt,
  input  logic                  id_usesRs,
  input  logic                  id_usesRt,
  input  logic                  id_isBranch,
  input  logic                  id_isLoad,
  input  logic                  id_writeRegister,
  input  logic [AW-1:0]         id_writeAddress,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  mem_writeRegister,
  input  logic [AW-1:0]         mem_writeAddress,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wb_writeRegister,
  input  logic [AW-1:0]         wb_writeAddress,
  input  logic [DATA_WIDTH-1:0] wb_writeData,
  output logic                  shouldStall,
  output logic [DATA_WIDTH-1:0] rsValue,
  output logic [DATA_WIDTH-1:0] rtValue,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_rsValue,
  output logic [DATA_WIDTH-1:0] ex_rtValue,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic                  ex_writeRegister,
  output logic [AW-1:0]         ex_writeAddress,
  output logic                  ex_isLoad
);

  logic [DATA_WIDTH-1:0] regFile [REG_COUNT];

  logic exForwardable;
  logic exHitRs, exHitRt;
  logic memHitRs, memHitRt;
  logic wbHitRs, wbHitRt;
  logic loadUse;
  logic captureReal;

  // Branches read operands in ID, but MEM data is final and EX ALU results
  // forward combinationally, so the load-use interlock is the only one needed.
  logic unusedIsBranch;
  assign unusedIsBranch = id_isBranch;

  // Register file: entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regFile[i] <= '0;
      end
    end else if (wb_writeRegister && (wb_writeAddress != '0)) begin
      regFile[wb_writeAddress] <= wb_writeData;
    end
  end

  // A load in EX has no data yet, so it is never a forwarding source.
  assign exForwardable = ex_valid && ex_writeRegister && !ex_isLoad;

  assign exHitRs  = exForwardable && (ex_writeAddress == id_rs);
  assign exHitRt  = exForwardable && (ex_writeAddress == id_rt);
  assign memHitRs = mem_writeRegister && (mem_writeAddress == id_rs);
  assign memHitRt = mem_writeRegister && (mem_writeAddress == id_rt);
  assign wbHitRs  = wb_writeRegister && (wb_writeAddress == id_rs);
  assign wbHitRt  = wb_writeRegister && (wb_writeAddress == id_rt);

  // rs operand: youngest producer wins, r0 is hardwired zero.
  always_comb begin
    rsValue = regFile[id_rs];
    if (id_rs == '0) begin
      rsValue = '0;
    end else if (exHitRs) begin
      rsValue = ex_result;
    end else if (memHitRs) begin
      rsValue = mem_data;
    end else if (wbHitRs) begin
      rsValue = wb_writeData;
    end
  end

  // rt operand: same priority chain as rs.
  always_comb begin
    rtValue = regFile[id_rt];
    if (id_rt == '0) begin
      rtValue = '0;
    end else if (exHitRt) begin
      rtValue = ex_result;
    end else if (memHitRt) begin
      rtValue = mem_data;
    end else if (wbHitRt) begin
      rtValue = wb_writeData;
    end
  end

  // Load-use interlock: one bubble lets the load reach MEM, where its data is final.
  always_comb begin
    loadUse = 1'b0;
    if (ex_valid && ex_isLoad && ex_writeRegister && (ex_writeAddress != '0) && id_valid) begin
      loadUse = (id_usesRs && (id_rs == ex_writeAddress)) ||
                (id_usesRt && (id_rt == ex_writeAddress));
    end
  end

  assign shouldStall = loadUse;
  assign captureReal = id_valid && !flush && !loadUse;

  // ID/EX register: flush, stall or an empty ID slot all inject a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid         <= 1'b0;
      ex_writeRegister <= 1'b0;
      ex_isLoad        <= 1'b0;
      ex_ctrl          <= '0;
      ex_rsValue       <= '0;
      ex_rtValue       <= '0;
      ex_writeAddress  <= '0;
    end else if (!captureReal) begin
      ex_valid         <= 1'b0;
      ex_writeRegister <= 1'b0;
      ex_isLoad        <= 1'b0;
      ex_ctrl          <= '0;
    end else begin
      ex_valid         <= 1'b1;
      ex_writeRegister <= id_writeRegister;
      ex_isLoad        <= id_isLoad;
      ex_ctrl          <= id_ctrl;
      ex_rsValue       <= rsValue;
      ex_rtValue       <= rtValue;
      ex_writeAddress  <= id_writeAddress;
    end
  end

endmodule

// File: tb/tb_id_forward_stage.sv
// tb/tb_id_forward_stage.sv - scoreboard bench for id_forward_stage
module tb_id_forward_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_usesRs, id_usesRt, id_isBranch, id_isLoad, id_writeRegister;
  logic [AW-1:0] id_rs, id_rt, id_writeAddress;
  logic [CW-1:0] id_ctrl;
  logic          flush;
  logic [DW-1:0] ex_result;
  logic          mem_writeRegister;
  logic [AW-1:0] mem_writeAddress;
  logic [DW-1:0] mem_data;
  logic          wb_writeRegister;
  logic [AW-1:0] wb_writeAddress;
  logic [DW-1:0] wb_writeData;
  logic          shouldStall;
  logic [DW-1:0] rsValue, rtValue, ex_rsValue, ex_rtValue;
  logic          ex_valid, ex_writeRegister, ex_isLoad;
  logic [CW-1:0] ex_ctrl;
  logic [AW-1:0] ex_writeAddress;

  id_forward_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_usesRs(id_usesRs), .id_usesRt(id_usesRt), .id_isBranch(id_isBranch),
    .id_isLoad(id_isLoad), .id_writeRegister(id_writeRegister),
    .id_writeAddress(id_writeAddress), .id_ctrl(id_ctrl), .flush(flush),
    .ex_result(ex_result), .mem_writeRegister(mem_writeRegister),
    .mem_writeAddress(mem_writeAddress), .mem_data(mem_data),
    .wb_writeRegister(wb_writeRegister), .wb_writeAddress(wb_writeAddress),
    .wb_writeData(wb_writeData), .shouldStall(shouldStall),
    .rsValue(rsValue), .rtValue(rtValue), .ex_valid(ex_valid),
    .ex_rsValue(ex_rsValue), .ex_rtValue(ex_rtValue), .ex_ctrl(ex_ctrl),
    .ex_writeRegister(ex_writeRegister), .ex_writeAddress(ex_writeAddress),
    .ex_isLoad(ex_isLoad)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_RS, S_RT, S_STALL, S_EXV, S_EXWR, S_EXLD, S_EXCTRL, S_EXRS, S_EXRT, S_EXWA
  } sel_t;

  typedef struct {
    int          cyc;
    sel_t        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] pick(sel_t s);
    case (s)
      S_RS:     return rsValue;
      S_RT:     return rtValue;
      S_STALL:  return {31'd0, shouldStall};
      S_EXV:    return {31'd0, ex_valid};
      S_EXWR:   return {31'd0, ex_writeRegister};
      S_EXLD:   return {31'd0, ex_isLoad};
      S_EXCTRL: return {16'd0, ex_ctrl};
      S_EXRS:   return ex_rsValue;
      S_EXRT:   return ex_rtValue;
      default:  return {27'd0, ex_writeAddress};
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for this cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      e   = sb.pop_front();
      act = pick(e.sel);
      checks++;
      if (e.cyc != cycle) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cycle);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.val, cycle);
      end
    end
  end

  task automatic expect_val(sel_t s, logic [31:0] v, string n);
    exp_t e;
    e.cyc = cycle; e.sel = s; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    id_valid = 0; id_rs = 0; id_rt = 0; id_usesRs = 0; id_usesRt = 0;
    id_isBranch = 0; id_isLoad = 0; id_writeRegister = 0; id_writeAddress = 0;
    id_ctrl = 0; flush = 0; ex_result = 0;
    mem_writeRegister = 0; mem_writeAddress = 0; mem_data = 0;
    wb_writeRegister = 0; wb_writeAddress = 0; wb_writeData = 0;
  endtask

  task automatic idInst(input logic [AW-1:0] rs, input logic urs, input logic [AW-1:0] rt,
                        input logic urt, input logic ld, input logic [AW-1:0] wa,
                        input logic [CW-1:0] ctrl);
    id_valid = 1; id_rs = rs; id_usesRs = urs; id_rt = rt; id_usesRt = urt;
    id_isLoad = ld; id_writeRegister = 1; id_writeAddress = wa; id_ctrl = ctrl;
  endtask

  initial begin
    rst_n = 0;
    clearIn();
    step();
    // Reset state
    expect_val(S_EXV, 0, "rst_ex_valid");
    expect_val(S_EXCTRL, 0, "rst_ex_ctrl");
    expect_val(S_EXRS, 0, "rst_ex_rsValue");
    expect_val(S_EXWA, 0, "rst_ex_writeAddress");
    step();
    rst_n = 1;

    // T1: WB write-through r5 while ID reads it; ALU to r7 enters EX
    step(); clearIn();
    idInst(5'd5, 1, 5'd6, 1, 0, 5'd7, 16'hABCD);
    wb_writeRegister = 1; wb_writeAddress = 5'd5; wb_writeData = 32'h1234;
    expect_val(S_RS, 32'h1234, "wb_writethrough_rs");
    expect_val(S_RT, 32'h0, "file_r6_zero");
    expect_val(S_STALL, 0, "t1_no_stall");

    // T2: file now holds r5; EX captured the r7 instruction
    step(); clearIn();
    id_rs = 5'd5;
    expect_val(S_RS, 32'h1234, "file_read_r5");
    expect_val(S_EXV, 1, "t2_ex_valid");
    expect_val(S_EXRS, 32'h1234, "t2_ex_rsValue");
    expect_val(S_EXCTRL, 16'hABCD, "t2_ex_ctrl");
    expect_val(S_EXWA, 7, "t2_ex_writeAddress");
    expect_val(S_EXWR, 1, "t2_ex_writeRegister");

    // T3: ALU to r3 enters EX
    step(); clearIn();
    idInst(5'd0, 0, 5'd0, 0, 0, 5'd3, 16'h0003);
    expect_val(S_EXV, 0, "t3_bubble");

    // T4: EX, MEM and WB all hit r3 -> EX wins
    step(); clearIn();
    ex_result = 32'd7;
    mem_writeRegister = 1; mem_writeAddress = 5'd3; mem_data = 32'd9;
    wb_writeRegister = 1; wb_writeAddress = 5'd3; wb_writeData = 32'h55;
    id_rt = 5'd3; id_rs = 5'd3;
    expect_val(S_RT, 32'd7, "ex_priority_rt");
    expect_val(S_RS, 32'd7, "ex_priority_rs");
    expect_val(S_EXWA, 3, "t4_ex_writeAddress");

    // T5: EX hit removed -> MEM beats WB
    step(); clearIn();
    mem_writeRegister = 1; mem_writeAddress = 5'd3; mem_data = 32'd9;
    wb_writeRegister = 1; wb_writeAddress = 5'd3; wb_writeData = 32'hAA;
    id_rt = 5'd3; id_rs = 5'd3;
    expect_val(S_RT, 32'd9, "mem_after_ex_removed");
    expect_val(S_RS, 32'd9, "mem_over_wb");
    expect_val(S_EXV, 0, "t5_bubble");

    // T6: file r3 holds last WB value; load to r4 enters EX
    step(); clearIn();
    id_rs = 5'd3;
    expect_val(S_RS, 32'hAA, "file_read_r3");
    idInst(5'd3, 0, 5'd0, 0, 1, 5'd4, 16'h0044);

    // T7: add uses r4 -> load-use stall
    step(); clearIn();
    idInst(5'd4, 1, 5'd0, 0, 0, 5'd0, 16'h0800);
    expect_val(S_STALL, 1, "load_use_stall");
    expect_val(S_EXLD, 1, "t7_ex_isLoad");
    expect_val(S_EXV, 1, "t7_ex_valid");

    // T8: load now in MEM -> forward, no stall, bubble in EX
    step(); clearIn();
    idInst(5'd4, 1, 5'd0, 0, 0, 5'd0, 16'h0800);
    mem_writeRegister = 1; mem_writeAddress = 5'd4; mem_data = 32'h4444;
    expect_val(S_EXV, 0, "stall_bubble");
    expect_val(S_STALL, 0, "stall_one_cycle");
    expect_val(S_RS, 32'h4444, "mem_forward_after_stall");

    // T9: r0 targeted by EX/MEM/WB with 0xFFFF -> reads 0; load to r0 enters EX
    step(); clearIn();
    ex_result = 32'hFFFF;
    mem_writeRegister = 1; mem_writeAddress = 5'd0; mem_data = 32'hFFFF;
    wb_writeRegister = 1; wb_writeAddress = 5'd0; wb_writeData = 32'hFFFF;
    expect_val(S_EXV, 1, "t9_ex_valid");
    expect_val(S_EXRS, 32'h4444, "t9_ex_rsValue");
    expect_val(S_EXWA, 0, "t9_ex_writeAddress");
    idInst(5'd0, 1, 5'd0, 1, 1, 5'd0, 16'h0F0F);
    expect_val(S_RS, 0, "r0_rs_zero");
    expect_val(S_RT, 0, "r0_rt_zero");
    expect_val(S_STALL, 0, "r0_no_stall");

    // T10: EX load to r0 is never a hazard; flush the ID instruction
    step(); clearIn();
    expect_val(S_EXLD, 1, "t10_ex_isLoad");
    idInst(5'd0, 1, 5'd0, 0, 0, 5'd9, 16'h0909);
    flush = 1;
    expect_val(S_STALL, 0, "load_r0_no_stall");

    // T11: flushed -> bubble; load to r10 enters EX
    step(); clearIn();
    expect_val(S_EXV, 0, "flush_ex_valid");
    expect_val(S_EXWR, 0, "flush_ex_writeRegister");
    expect_val(S_EXCTRL, 0, "flush_ex_ctrl");
    idInst(5'd0, 0, 5'd0, 0, 1, 5'd10, 16'h1010);

    // T12: stall and flush together -> stall still reported
    step(); clearIn();
    expect_val(S_EXLD, 1, "t12_ex_isLoad");
    idInst(5'd0, 0, 5'd10, 1, 0, 5'd1, 16'h2222);
    flush = 1;
    expect_val(S_STALL, 1, "stall_with_flush");

    // T13: bubble; real instruction reading r5 enters EX
    step(); clearIn();
    expect_val(S_EXV, 0, "t13_bubble");
    expect_val(S_EXCTRL, 0, "t13_ex_ctrl");
    idInst(5'd5, 1, 5'd0, 0, 1, 5'd12, 16'h1111);

    // T14: load r12 in EX; ID uses r12 -> stall
    step(); clearIn();
    expect_val(S_EXV, 1, "t14_ex_valid");
    expect_val(S_EXCTRL, 16'h1111, "t14_ex_ctrl");
    expect_val(S_EXRS, 32'h1234, "t14_ex_rsValue");
    idInst(5'd12, 1, 5'd5, 0, 0, 5'd13, 16'h3333);
    expect_val(S_STALL, 1, "t14_stall");

    // T15: recapture load r12 so reset lands while the stall is pending
    step(); clearIn();
    idInst(5'd5, 1, 5'd0, 0, 1, 5'd12, 16'h1111);

    // T16: asynchronous reset mid-stall
    step();
    idInst(5'd12, 1, 5'd5, 1, 0, 5'd13, 16'h3333);
    rst_n = 0;
    expect_val(S_EXV, 0, "arst_ex_valid");
    expect_val(S_EXWR, 0, "arst_ex_writeRegister");
    expect_val(S_EXLD, 0, "arst_ex_isLoad");
    expect_val(S_EXCTRL, 0, "arst_ex_ctrl");
    expect_val(S_EXRS, 0, "arst_ex_rsValue");
    expect_val(S_EXRT, 0, "arst_ex_rtValue");
    expect_val(S_EXWA, 0, "arst_ex_writeAddress");
    expect_val(S_STALL, 0, "arst_no_stall");
    expect_val(S_RT, 0, "arst_file_r5_cleared");

    // T17: out of reset, file still clear
    step(); clearIn();
    rst_n = 1;
    id_rs = 5'd5; id_rt = 5'd3;
    expect_val(S_RS, 0, "post_rst_r5");
    expect_val(S_RT, 0, "post_rst_r3");

    repeat (3) step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never checked, expected %h", e.name, e.val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench timed out at cycle %0d, required completion", cycle);
    $fatal(1);
  end

endmodule
